// File: rtl/mem_ctrl_pipe.sv
// Single-port memory controller: valid/ready requests, byte strobes, RD_LAT-deep read pipeline,
// post-reset clear and out-of-range errors. Define MEM_CTRL_PARITY_EN for per-lane parity and par_inj.
module mem_ctrl_pipe #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256,
   parameter int RD_LAT = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_rd_wr,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [DATA_W/8-1:0]   req_wstrb,
`ifdef MEM_CTRL_PARITY_EN
   input  logic                  par_inj,
`endif
   output logic                  rsp_valid,
   output logic [DATA_W-1:0]     rsp_data,
   output logic                  rsp_err,
   output logic                  init_done
);

   localparam int NB = DATA_W / 8;
`ifdef MEM_CTRL_PARITY_EN
   localparam int MEM_W = DATA_W + NB;
`else
   localparam int MEM_W = DATA_W;
`endif
   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]        state;
   logic [ADDR_W:0]   clr_cnt;
   logic              clr_active;
   logic              accept;
   logic              in_range;
   logic              rd_acc;
   logic              wr_acc;
   logic              rd_err;
   logic [MEM_W-1:0]  cur_word;
   logic [MEM_W-1:0]  new_word;

   logic [MEM_W-1:0]  mem [DEPTH];

   logic [RD_LAT-1:0] pipe_v;
   logic [RD_LAT-1:0] pipe_e;
   logic [DATA_W-1:0] pipe_d [RD_LAT];

   assign req_ready  = (state == ST_RUN);
   assign init_done  = (state == ST_RUN);
   assign clr_active = (state == ST_INIT) && (clr_cnt != DEPTH_W);
   assign accept     = req_valid && req_ready;
   assign in_range   = ({1'b0, req_addr} < DEPTH_W);
   assign rd_acc     = accept && req_rd_wr;
   assign wr_acc     = accept && !req_rd_wr && in_range;
   assign cur_word   = mem[req_addr];

   // Merge enabled lanes into the stored word; disabled lanes keep their old bytes.
   always_comb begin
      // NOTE: every combinationally assigned signal gets a full default first, so no path leaves it unassigned and no latch is inferred.
      new_word = cur_word;
      for (int i = 0; i < NB; i++) begin
         if (req_wstrb[i]) begin
            new_word[8*i +: 8] = req_wdata[8*i +: 8];
`ifdef MEM_CTRL_PARITY_EN
            new_word[DATA_W + i] = ^req_wdata[8*i +: 8];
`endif
         end
      end
`ifdef MEM_CTRL_PARITY_EN
      new_word[DATA_W] = new_word[DATA_W] ^ par_inj;
`endif
   end

   always_comb begin
      rd_err = !in_range;
`ifdef MEM_CTRL_PARITY_EN
      for (int i = 0; i < NB; i++) begin
         if (in_range && ((^cur_word[8*i +: 8]) != cur_word[DATA_W + i])) begin
            rd_err = 1'b1;
         end
      end
`endif
   end

   // Clear counter runs one step past DEPTH-1 so the hand-over to RUN lands DEPTH cycles after release.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!reset_n) begin
         state   <= ST_INIT;
         clr_cnt <= '0;
      end else if (state == ST_INIT) begin
         if (clr_cnt == DEPTH_W) begin
            state <= ST_RUN;
         end else begin
            clr_cnt <= clr_cnt + 1'b1;
         end
      end
   end

   // NOTE: the storage array has no reset branch; it is zeroed word by word by the INIT sweep instead.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         if (clr_active) begin
            mem[clr_cnt[ADDR_W-1:0]] <= '0;
         end else if (wr_acc) begin
            mem[req_addr] <= new_word;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pipe_v <= '0;
         pipe_e <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_d[i] <= '0;
         end
      end else begin
         pipe_v[0] <= rd_acc;
         pipe_e[0] <= rd_acc && rd_err;
         pipe_d[0] <= (rd_acc && in_range) ? cur_word[DATA_W-1:0] : '0;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_e[i] <= pipe_e[i-1];
            pipe_d[i] <= pipe_d[i-1];
         end
      end
   end

   assign rsp_valid = pipe_v[RD_LAT-1];
   assign rsp_err   = pipe_e[RD_LAT-1];
   assign rsp_data  = pipe_d[RD_LAT-1];

endmodule

// File: tb/tb_mem_ctrl_pipe.sv
// Directed bench for mem_ctrl_pipe (32-bit, DEPTH 200, RD_LAT 3); parity vectors run when
// MEM_CTRL_PARITY_EN is defined.
module tb_mem_ctrl_pipe;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 200;
   localparam int RD_LAT = 3;

   typedef struct {
      int          due;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_rd_wr = 1'b0;
   logic [7:0]  req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_wstrb = '0;
`ifdef MEM_CTRL_PARITY_EN
   logic        par_inj = 1'b0;
`endif
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        init_done;

   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   logic mon_en = 1'b0;
   logic mon_exp_v;
   exp_t exp_q[$];

   mem_ctrl_pipe #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_rd_wr (req_rd_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
`ifdef MEM_CTRL_PARITY_EN
      .par_inj   (par_inj),
`endif
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .init_done (init_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Response monitor: a response must appear exactly on its due cycle and nowhere else.
   always @(negedge clk) begin
      if (mon_en) begin
         mon_exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
         check("rsp_valid", {31'b0, rsp_valid}, {31'b0, mon_exp_v});
         if (mon_exp_v) begin
            check("rsp_data", rsp_data, exp_q[0].data);
            check("rsp_err", {31'b0, rsp_err}, {31'b0, exp_q[0].err});
            void'(exp_q.pop_front());
         end else begin
            check("rsp_data_idle", rsp_data, 32'h0);
         end
      end
   end

   // Called at a falling edge; the request is accepted on the following rising edge.
   task automatic drive(input logic rd, input logic [7:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, input logic inj,
                        input logic [31:0] ed, input logic ee);
      exp_t e;
      check("req_ready", {31'b0, req_ready}, 32'h1);
      req_valid = 1'b1;
      req_rd_wr = rd;
      req_addr  = addr;
      req_wdata = wd;
      req_wstrb = strb;
`ifdef MEM_CTRL_PARITY_EN
      par_inj   = inj;
`endif
      if (rd) begin
         e.due  = cyc + RD_LAT;
         e.data = ed;
         e.err  = ee;
         exp_q.push_back(e);
      end
      @(negedge clk);
      req_valid = 1'b0;
`ifdef MEM_CTRL_PARITY_EN
      par_inj   = 1'b0;
`endif
   endtask

   task automatic wr(input logic [7:0] addr, input logic [31:0] wd, input logic [3:0] strb);
      drive(1'b0, addr, wd, strb, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic rd(input logic [7:0] addr, input logic [31:0] ed, input logic ee);
      drive(1'b1, addr, 32'h0, 4'h0, 1'b0, ed, ee);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input int hold);
      int n;
      reset_n   = 1'b0;
      req_valid = 1'b0;
      exp_q.delete();
      repeat (hold) @(negedge clk);
      mon_en = 1'b1;
      check("rst_req_ready", {31'b0, req_ready}, 32'h0);
      check("rst_init_done", {31'b0, init_done}, 32'h0);
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
      check("rst_rsp_data", rsp_data, 32'h0);
      check("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
      reset_n = 1'b1;
      n = 0;
      for (int k = 0; k < DEPTH + 20; k++) begin
         @(negedge clk);
         if (req_ready) break;
         n++;
      end
      check("clear_cycles", n, DEPTH);
      check("init_done", {31'b0, init_done}, 32'h1);
   endtask

   initial begin
      do_reset(3);

      // Cleared memory reads back as zero, back-to-back.
      for (int a = 0; a < 16; a++) rd(8'(a), 32'h0, 1'b0);
      rd(8'd199, 32'h0, 1'b0);
      idle(RD_LAT + 1);

      // Byte strobes, read straight after the write.
      wr(8'd5, 32'hAABBCCDD, 4'hF);
      wr(8'd5, 32'h11223344, 4'b0101);
      rd(8'd5, 32'hAA22CC44, 1'b0);
      wr(8'd5, 32'hFFFFFFFF, 4'h0);
      rd(8'd5, 32'hAA22CC44, 1'b0);
      idle(2);

      // Latency and throughput with four back-to-back reads.
      wr(8'd1, 32'h10, 4'hF);
      wr(8'd2, 32'h11, 4'hF);
      wr(8'd3, 32'h12, 4'hF);
      wr(8'd4, 32'h13, 4'hF);
      idle(1);
      rd(8'd1, 32'h10, 1'b0);
      rd(8'd2, 32'h11, 1'b0);
      rd(8'd3, 32'h12, 1'b0);
      rd(8'd4, 32'h13, 1'b0);
      idle(RD_LAT + 2);

      // Out-of-range boundaries and read-after-write.
      wr(8'd201, 32'h5A, 4'hF);
      rd(8'd201, 32'h0, 1'b1);
      wr(8'd199, 32'hCAFE0199, 4'hF);
      rd(8'd199, 32'hCAFE0199, 1'b0);
      wr(8'd200, 32'h77, 4'hF);
      rd(8'd200, 32'h0, 1'b1);
      wr(8'd3, 32'h7E, 4'hF);
      rd(8'd3, 32'h7E, 1'b0);
      wr(8'd8, 32'h00001234, 4'hF);
      rd(8'd8, 32'h00001234, 1'b0);
      wr(8'd8, 32'h0000AB00, 4'b0010);
      rd(8'd8, 32'h0000AB34, 1'b0);
      rd(8'd1, 32'h10, 1'b0);
      idle(RD_LAT + 2);

      // Reset one edge after a read is accepted: its response must never show.
      rd(8'd5, 32'hAA22CC44, 1'b0);
      do_reset(1);
      rd(8'd5, 32'h0, 1'b0);
      rd(8'd3, 32'h0, 1'b0);
      rd(8'd199, 32'h0, 1'b0);
      idle(RD_LAT + 1);

`ifdef MEM_CTRL_PARITY_EN
      drive(1'b0, 8'd7, 32'h01, 4'hF, 1'b1, 32'h0, 1'b0);
      rd(8'd7, 32'h01, 1'b1);
      drive(1'b0, 8'd7, 32'h01, 4'hF, 1'b0, 32'h0, 1'b0);
      rd(8'd7, 32'h01, 1'b0);
      idle(RD_LAT + 1);
`endif

      idle(RD_LAT + 3);
      check("pending_responses", exp_q.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
